nor_32: RTL and testbench
=========================

// Module: nor_32
// PURPOSE
//   32-bit bitwise NOR with a registered output: res = ~(a | b), one bit per lane.
//   Logic-unit building block for the ALU datapath, alongside the other 32-bit bitwise units.
//   Combinational NOR array built from 1-bit gate slices, followed by one output register stage.
// PARAMETERS
//   WIDTH  32  operand/result width in bits; only 32 is supported and verified.
// PORTS
//   clk  input   1      system clock; all state updates on the rising edge
//   rst  input   1      synchronous reset, active-high, sampled on rising clk
//   a    input   WIDTH  operand A
//   b    input   WIDTH  operand B
//   res  output  WIDTH  registered result, ~(a | b) of the previous cycle's operands
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high.
//   - Per rising clk edge:
//       rst=1 -> res <= 32'h0000_0000
//       rst=0 -> res <= ~(a | b), bit i = ~(a[i] | b[i]) for i = 0..31
//   - Reset value of res is all-zeros. It is not NOR(0,0) = all-ones.
//   - Latency is exactly 1 cycle, throughput is 1 result per cycle.
//   - No handshake and no stall. Inputs are sampled every edge.
//   - Bits are independent: no carry, no cross-lane interaction, no overflow.
//   - rst takes priority over the data path.
//     - rst asserted mid-stream: res = 0 at the next edge, whatever a/b hold.
//     - First edge after rst deasserts: res = ~(a | b) of the operands sampled at that edge.
//   - X/Z on any input bit propagates to that result bit only.
//   - res is driven only by the register. There is no combinational path from a/b to res.
// STRUCTURE
//   - No shared package needed. WIDTH is the only constant and stays local.
//   - Sub-module nor_1: 1-bit gate-level NOR (out, x, y) using or + not primitives.
//   - nor_32 instantiates 32 nor_1 slices in a generate loop, producing nor_comb[31:0].
//   - The nor_comb bus feeds a single 32-bit always @(posedge clk) register with synchronous rst.
// TESTING
//   1. rst=1 two cycles with a=32'hFFFF_FFFF, b=0 -> res=32'h0000_0000 after first edge.
//   2. rst=0, a=32'h0000_0039, b=32'h0000_0003 -> res=32'hFFFF_FFC4 one edge later.
//   3. a=32'h0000_0002, b=32'h0000_0001 -> res=32'hFFFF_FFFC one edge later.
//      Back-to-back with scenario 2, no bubble.
//   4. a=0, b=0 -> 32'hFFFF_FFFF; a=32'hAAAA_AAAA, b=32'h5555_5555 -> 32'h0000_0000.
//   5. Mid-stream reset: a=b=0 steady, assert rst for 1 cycle -> res=0 that edge,
//      then 32'hFFFF_FFFF on the next edge after deassert.
//   6. Random a/b for 1000 cycles -> res equals ~(a|b) of the previous cycle, bit-exact.

Source files
------------

// File: rtl/nor_1.sv
// rtl/nor_1.sv - one-bit gate-level NOR slice
module nor_1 (
   output wire out,
   input  wire x,
   input  wire y
);

   wire or_xy;

   or  u_or  (or_xy, x, y);
   not u_not (out, or_xy);

endmodule

// File: rtl/nor_32.sv
// rtl/nor_32.sv - 32-bit bitwise NOR built from gate slices, one output register stage
module nor_32 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] res
);

   wire [WIDTH-1:0] nor_comb;

   // Lanes are fully independent, so an unknown operand bit only taints its own result bit.
   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      nor_1 u_nor (
         .out (nor_comb[i]),
         .x   (a[i]),
         .y   (b[i])
      );
   end

   // Reset clears to zero rather than NOR(0,0) so a fresh unit reads as idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         res <= '0;
      end else begin
         res <= nor_comb;
      end
   end

endmodule

// File: tb/tb_nor_32.sv
// tb/tb_nor_32.sv - self-checking bench for nor_32: directed table, corner sequences, random vs model
module tb_nor_32;

   logic        clk;
   logic        rst;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] res;

   int total;
   int bad;

   typedef struct {
      logic        rst;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[$];

   nor_32 #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .a   (a),
      .b   (b),
      .res (res)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: a result bit is 1 exactly when neither operand bit is set; reset forces zero.
   function automatic logic [31:0] model(input logic r, input logic [31:0] x, input logic [31:0] y);
      logic [31:0] m;
      m = 32'd0;
      if (!r) begin
         for (int i = 0; i < 32; i++) begin
            if (x[i] == 1'b0 && y[i] == 1'b0) m = m + (32'd1 << i);
         end
      end
      return m;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %08h want %08h", name, got, want);
      end
   endtask

   task automatic apply(input logic r, input logic [31:0] x, input logic [31:0] y);
      rst = r;
      a   = x;
      b   = y;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rr;
      logic [31:0] held;

      total = 0;
      bad   = 0;
      rst   = 1'b1;
      a     = 32'd0;
      b     = 32'd0;

      vecs.push_back('{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, "reset_1"});
      vecs.push_back('{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, "reset_2"});
      vecs.push_back('{1'b0, 32'h0000_0039, 32'h0000_0003, 32'hFFFF_FFC4, "nor_39_03"});
      vecs.push_back('{1'b0, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFC, "nor_02_01"});
      vecs.push_back('{1'b0, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, "nor_zero"});
      vecs.push_back('{1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, "nor_alt"});
      vecs.push_back('{1'b0, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFE, "nor_edges"});
      vecs.push_back('{1'b0, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, "pre_midrst"});
      vecs.push_back('{1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, "midrst"});
      vecs.push_back('{1'b0, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, "post_midrst"});
      vecs.push_back('{1'b0, 32'hF0F0_0000, 32'h000F_0F00, 32'h0F00_F0FF, "nor_mix"});

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].rst, vecs[i].a, vecs[i].b);
         check(vecs[i].name, res, vecs[i].exp);
      end

      // Operand changes between edges must not reach res until the next edge.
      held = res;
      a = 32'hFFFF_FFFF;
      b = 32'hFFFF_FFFF;
      #3;
      check("no_comb_path", res, held);
      @(posedge clk);
      #1;
      check("after_edge", res, 32'h0000_0000);

      // Reset dominates even when operands would give all-ones.
      apply(1'b1, 32'h0, 32'h0);
      check("rst_priority", res, 32'h0000_0000);
      apply(1'b0, 32'h1234_5678, 32'h0F0F_0000);
      check("first_after_rst", res, ~(32'h1234_5678 | 32'h0F0F_0000));

      for (int n = 0; n < 1000; n++) begin
         ra = $urandom;
         rb = $urandom;
         rr = ($urandom_range(0, 15) == 0);
         apply(rr, ra, rb);
         check("random", res, model(rr, ra, rb));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
